// File: rtl/ap_handshake_event_recorder.sv
// ap_handshake_event_recorder
//
// Watches one HLS block's ap_start/ap_ready/ap_done/ap_continue handshake.
// It turns every completed transaction into a timestamped record {txn_id,
// start_ts, end_ts, latency, stall, flags}. Records are buffered in a
// first-word-fall-through FIFO that a downstream status dumper drains
// through a valid/ready port.
//
// Optional feature: define HS_RECORDER_STALL_COUNT_EN to count the cycles
// with ap_done=1 and ap_continue=0 for each transaction. When the macro is
// undefined, rec_stall is constant 0 and the port widths stay the same.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   ap_start     monitored block start
//   ap_ready     monitored block ready (input accepted)
//   ap_done      monitored block done
//   ap_continue  monitored block continue
//   finish       end-of-simulation request (latched)
//   rec_valid    record available at the FIFO head
//   rec_ready    consumer accepts the head record
//   rec_txn_id   transaction ID
//   rec_start_ts cycle count at start capture
//   rec_end_ts   cycle count at done&continue
//   rec_latency  end - start, modulo 2^TS_W
//   rec_stall    done-but-not-continued cycles before completion
//   rec_flags    [0] orphan end, [1] start dropped since previous record
//   inflight     number of queued start timestamps
//   drop_cnt     records lost to a full output FIFO (saturating)
//   drained      finish seen, no start pending, output FIFO empty
module ap_handshake_event_recorder #(
  parameter int TS_W         = 32,
  parameter int ID_W         = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic                          ap_ready,
  input  logic                          ap_done,
  input  logic                          ap_continue,
  input  logic                          finish,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [ID_W-1:0]               rec_txn_id,
  output logic [TS_W-1:0]               rec_start_ts,
  output logic [TS_W-1:0]               rec_end_ts,
  output logic [TS_W-1:0]               rec_latency,
  output logic [STALL_W-1:0]            rec_stall,
  output logic [1:0]                    rec_flags,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic [15:0]                   drop_cnt,
  output logic                          drained
);

  localparam int SQ_AW = $clog2(MAX_INFLIGHT);
  localparam int OF_AW = $clog2(FIFO_DEPTH);
  localparam int REC_W = ID_W + 3*TS_W + STALL_W + 2;
  localparam logic [SQ_AW:0] SQ_FULL = (SQ_AW+1)'(MAX_INFLIGHT);
  localparam logic [OF_AW:0] OF_FULL = (OF_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_DRAINED = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t state;

  logic [TS_W-1:0]    cyc;
  logic               armed;
  logic               drop_flag;
  logic [TS_W-1:0]    sq_mem [MAX_INFLIGHT];
  logic [SQ_AW-1:0]   sq_wr;
  logic [SQ_AW-1:0]   sq_rd;
  logic [SQ_AW:0]     sq_cnt;
  logic [ID_W-1:0]    txn_id;
  logic [STALL_W-1:0] stall_cnt;

  logic start_ev;
  logic end_ev;
  logic sq_full;
  logic sq_push;
  logic sq_drop;
  logic sq_pop;

  // Starts are ignored as soon as finish shows up, including its first cycle.
  assign start_ev = ap_start & armed & (state == S_RUN) & ~finish;
  assign end_ev   = ap_done & ap_continue;
  assign sq_full  = (sq_cnt == SQ_FULL);
  // A start that finds the queue full is dropped even if an end pops in the
  // same cycle; the drop is reported through the sticky flag.
  assign sq_push  = start_ev & ~sq_full;
  assign sq_drop  = start_ev & sq_full;
  assign sq_pop   = end_ev & (sq_cnt != '0);

  // ---- stage p0: handshake decode, start queue, ID / cycle counters ----
  logic               vld_p1;
  logic [ID_W-1:0]    id_p1;
  logic [TS_W-1:0]    start_p1;
  logic [TS_W-1:0]    end_p1;
  logic [TS_W-1:0]    lat_p1;
  logic [STALL_W-1:0] stall_p1;
  logic [1:0]         flags_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc       <= '0;
      armed     <= 1'b1;
      drop_flag <= 1'b0;
      sq_wr     <= '0;
      sq_rd     <= '0;
      sq_cnt    <= '0;
      txn_id    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      cyc <= cyc + 1'b1;
      // ready re-arms; a start with same-cycle ready keeps the flag set
      if (ap_start & ap_ready)
        armed <= 1'b1;
      else if (start_ev)
        armed <= 1'b0;
      drop_flag <= sq_drop | (drop_flag & ~end_ev);
      if (sq_push) sq_wr <= sq_wr + 1'b1;
      if (sq_pop)  sq_rd <= sq_rd + 1'b1;
      case ({sq_push, sq_pop})
        2'b10:   sq_cnt <= sq_cnt + 1'b1;
        2'b01:   sq_cnt <= sq_cnt - 1'b1;
        default: sq_cnt <= sq_cnt;
      endcase
      if (end_ev) txn_id <= txn_id + 1'b1;
      vld_p1 <= end_ev;
    end
  end

`ifdef HS_RECORDER_STALL_COUNT_EN
  function automatic logic [STALL_W-1:0] sat_inc_stall(input logic [STALL_W-1:0] v);
    return (v == {STALL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= '0;
    else if (end_ev)
      stall_cnt <= '0;
    else if (ap_done & ~ap_continue)
      stall_cnt <= sat_inc_stall(stall_cnt);
  end
`else
  assign stall_cnt = '0;
`endif

  // Record build. The pop reads the head as it stood before any same-cycle
  // push, so an end with an empty queue is an orphan even if a start lands.
  always_ff @(posedge clock) begin
    if (sq_push) sq_mem[sq_wr] <= cyc;
    if (end_ev) begin
      id_p1    <= txn_id;
      end_p1   <= cyc;
      stall_p1 <= stall_cnt;
      if (sq_cnt != '0) begin
        start_p1 <= sq_mem[sq_rd];
        lat_p1   <= cyc - sq_mem[sq_rd];
        flags_p1 <= {drop_flag, 1'b0};
      end else begin
        start_p1 <= cyc;
        lat_p1   <= '0;
        flags_p1 <= {drop_flag, 1'b1};
      end
    end
  end

  // ---- stage p1: record enters the output FIFO ----
  logic [REC_W-1:0] of_mem [FIFO_DEPTH];
  logic [OF_AW-1:0] of_wr;
  logic [OF_AW-1:0] of_rd;
  logic [OF_AW:0]   of_cnt;
  logic             of_full;
  logic             of_push;
  logic             of_pop;
  logic             of_drop;
  logic [REC_W-1:0] of_head;

  assign of_full   = (of_cnt == OF_FULL);
  assign rec_valid = (of_cnt != '0);
  assign of_pop    = rec_valid & rec_ready;
  // a full FIFO still accepts a record when the head leaves in the same cycle
  assign of_push   = vld_p1 & (~of_full | of_pop);
  assign of_drop   = vld_p1 & of_full & ~of_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      of_wr    <= '0;
      of_rd    <= '0;
      of_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (of_push) of_wr <= of_wr + 1'b1;
      if (of_pop)  of_rd <= of_rd + 1'b1;
      case ({of_push, of_pop})
        2'b10:   of_cnt <= of_cnt + 1'b1;
        2'b01:   of_cnt <= of_cnt - 1'b1;
        default: of_cnt <= of_cnt;
      endcase
      if (of_drop) drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (of_push)
      of_mem[of_wr] <= {id_p1, start_p1, end_p1, lat_p1, stall_p1, flags_p1};
  end

  // Stale storage is masked so the record fields read 0 while nothing is valid.
  assign of_head = rec_valid ? of_mem[of_rd] : '0;
  assign {rec_txn_id, rec_start_ts, rec_end_ts, rec_latency, rec_stall, rec_flags} = of_head;
  assign inflight = sq_cnt;

  // Run / flush / drained sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (finish) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // a record still in the build stage counts as pending output
          if ((sq_cnt == '0) && (of_cnt == '0) && !vld_p1) begin
            state   <= S_DRAINED;
            drained <= 1'b1;
          end
        end
        S_DRAINED: begin
          drained <= 1'b1;
        end
        default: begin
          state   <= S_RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ap_handshake_event_recorder.sv
module tb_ap_handshake_event_recorder;

  localparam int TS_W = 32;
  localparam int ID_W = 16;
  localparam int MAX_INFLIGHT = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int STALL_W = 16;

`ifdef HS_RECORDER_STALL_COUNT_EN
  localparam logic [STALL_W-1:0] EXP_STALL = 16'd2;
`else
  localparam logic [STALL_W-1:0] EXP_STALL = 16'd0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic finish = 1'b0;
  logic rec_ready = 1'b1;
  logic rec_valid;
  logic [ID_W-1:0] rec_txn_id;
  logic [TS_W-1:0] rec_start_ts, rec_end_ts, rec_latency;
  logic [STALL_W-1:0] rec_stall;
  logic [1:0] rec_flags;
  logic [$clog2(MAX_INFLIGHT):0] inflight;
  logic [15:0] drop_cnt;
  logic drained;

  ap_handshake_event_recorder #(
    .TS_W(TS_W), .ID_W(ID_W), .MAX_INFLIGHT(MAX_INFLIGHT),
    .FIFO_DEPTH(FIFO_DEPTH), .STALL_W(STALL_W)
  ) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_txn_id(rec_txn_id), .rec_start_ts(rec_start_ts), .rec_end_ts(rec_end_ts),
    .rec_latency(rec_latency), .rec_stall(rec_stall), .rec_flags(rec_flags),
    .inflight(inflight), .drop_cnt(drop_cnt), .drained(drained)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ID_W-1:0]    id;
    logic [TS_W-1:0]    st;
    logic [TS_W-1:0]    en;
    logic [TS_W-1:0]    lat;
    logic [STALL_W-1:0] stall;
    logic [1:0]         flags;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [TS_W-1:0] tb_cyc;
  logic [ID_W-1:0] exp_id;

  // reference time base: 0 in the first cycle after reset, +1 per clock
  always @(posedge clock) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 1;
  end

  // scoreboard: compare each accepted record against the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rec_valid && rec_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_record got id=%0d start=%0d end=%0d required none",
                 rec_txn_id, rec_start_ts, rec_end_ts);
      end else begin
        e = exp_q.pop_front();
        if (rec_txn_id !== e.id || rec_start_ts !== e.st || rec_end_ts !== e.en ||
            rec_latency !== e.lat || rec_stall !== e.stall || rec_flags !== e.flags) begin
          n_err++;
          $display("FAIL record got id=%0d st=%0d en=%0d lat=%0d stall=%0d fl=%b required id=%0d st=%0d en=%0d lat=%0d stall=%0d fl=%b",
                   rec_txn_id, rec_start_ts, rec_end_ts, rec_latency, rec_stall, rec_flags,
                   e.id, e.st, e.en, e.lat, e.stall, e.flags);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (tb_cyc < c) tick;
  endtask

  task automatic push_exp(input logic [TS_W-1:0] st, input logic [TS_W-1:0] en,
                          input logic [STALL_W-1:0] stall, input logic [1:0] flags);
    exp_t e;
    e.id = exp_id; e.st = st; e.en = en; e.lat = en - st; e.stall = stall; e.flags = flags;
    exp_q.push_back(e);
    exp_id++;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
    rec_ready = 1'b1;
    tick; tick;
    reset = 1'b0;
    exp_q.delete();
    exp_id = '0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if (rec_valid !== 1'b0) begin n_err++; $display("FAIL reset_rec_valid got %b required 0", rec_valid); end
    n_cmp++;
    if ({rec_txn_id, rec_start_ts, rec_end_ts, rec_latency, rec_stall, rec_flags} !== '0) begin
      n_err++; $display("FAIL reset_rec_fields got id=%0d st=%0d en=%0d required all 0", rec_txn_id, rec_start_ts, rec_end_ts);
    end
    n_cmp++;
    if (inflight !== '0 || drop_cnt !== 16'd0 || drained !== 1'b0) begin
      n_err++; $display("FAIL reset_status got inflight=%0d drop=%0d drained=%b required 0/0/0", inflight, drop_cnt, drained);
    end
  endtask

  task automatic test_single;
    do_reset;
    wait_cyc(5);
    ap_start = 1; ap_ready = 1;
    tick;
    ap_start = 0; ap_ready = 0;
    n_cmp++;
    if (inflight !== 3'd1) begin n_err++; $display("FAIL single_inflight_up got %0d required 1", inflight); end
    wait_cyc(12);
    ap_done = 1; ap_continue = 1;
    push_exp(32'd5, 32'd12, '0, 2'b00);
    tick;
    ap_done = 0;
    n_cmp++;
    if (inflight !== 3'd0) begin n_err++; $display("FAIL single_inflight_down got %0d required 0", inflight); end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain pending %0d required 0", exp_q.size()); end
  endtask

  task automatic test_pipelined;
    int peak = 0;
    do_reset;
    wait_cyc(10);
    while (tb_cyc < 26) begin
      ap_start = (tb_cyc == 10 || tb_cyc == 12 || tb_cyc == 14);
      ap_ready = ap_start;
      ap_done  = (tb_cyc == 20 || tb_cyc == 22 || tb_cyc == 24);
      ap_continue = ap_done;
      if (ap_done) push_exp(tb_cyc - 10, tb_cyc, '0, 2'b00);
      tick;
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    n_cmp++;
    if (peak != 3) begin n_err++; $display("FAIL pipelined_peak_inflight got %0d required 3", peak); end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL pipelined_drain pending %0d required 0", exp_q.size()); end
  endtask

  task automatic test_orphan;
    do_reset;
    wait_cyc(8);
    ap_done = 1; ap_continue = 1;
    push_exp(32'd8, 32'd8, '0, 2'b01);
    tick;
    ap_done = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    n_cmp++;
    if (exp_q.size() != 0 || inflight !== 3'd0) begin
      n_err++; $display("FAIL orphan_drain pending %0d inflight %0d required 0/0", exp_q.size(), inflight);
    end
  endtask

  task automatic test_overflow;
    logic [TS_W-1:0] base;
    do_reset;
    wait_cyc(2);
    base = tb_cyc;
    ap_start = 1; ap_ready = 1;
    repeat (5) tick;
    ap_start = 0; ap_ready = 0;
    n_cmp++;
    if (inflight !== 3'd4) begin n_err++; $display("FAIL overflow_inflight got %0d required 4", inflight); end
    ap_done = 1; ap_continue = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)     push_exp(base, tb_cyc, '0, 2'b10);
      else if (i < 4) push_exp(base + i, tb_cyc, '0, 2'b00);
      else            push_exp(tb_cyc, tb_cyc, '0, 2'b01);
      tick;
    end
    ap_done = 0; ap_continue = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL overflow_drain pending %0d required 0", exp_q.size()); end
  endtask

  task automatic test_fifo_full;
    do_reset;
    rec_ready = 0;
    for (int i = 0; i < 10; i++) begin
      logic [TS_W-1:0] s;
      s = tb_cyc;
      ap_start = 1; ap_ready = 1;
      tick;
      ap_start = 0; ap_ready = 0;
      ap_done = 1; ap_continue = 1;
      if (i < 8) push_exp(s, tb_cyc, '0, 2'b00);
      else exp_id++;
      tick;
      ap_done = 0; ap_continue = 0;
    end
    tick; tick; tick;
    n_cmp++;
    if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL fifo_drop_cnt got %0d required 2", drop_cnt); end
    n_cmp++;
    if (rec_valid !== 1'b1 || rec_txn_id !== 16'd0) begin
      n_err++; $display("FAIL fifo_head_held got valid=%b id=%0d required 1/0", rec_valid, rec_txn_id);
    end
    rec_ready = 1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL fifo_drain pending %0d required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    wait_cyc(3);
    ap_start = 1; ap_ready = 1;
    tick;
    ap_start = 0; ap_ready = 0;
    wait_cyc(6);
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    push_exp(32'd3, 32'd6, '0, 2'b00);
    tick;
    ap_start = 0; ap_ready = 0; ap_done = 0;
    n_cmp++;
    if (inflight !== 3'd1) begin n_err++; $display("FAIL b2b_inflight got %0d required 1", inflight); end
    wait_cyc(9);
    ap_done = 1;
    push_exp(32'd6, 32'd9, '0, 2'b00);
    tick;
    ap_done = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    n_cmp++;
    if (exp_q.size() != 0 || inflight !== 3'd0) begin
      n_err++; $display("FAIL b2b_drain pending %0d inflight %0d required 0/0", exp_q.size(), inflight);
    end
  endtask

  task automatic test_finish_stall;
    logic [TS_W-1:0] s;
    int waited;
    do_reset;
    rec_ready = 0;
    wait_cyc(4);
    s = tb_cyc;
    ap_start = 1; ap_ready = 1;
    tick;
    ap_start = 0; ap_ready = 0;
    finish = 1;
    tick;
    finish = 0;
    ap_start = 1; ap_ready = 1;   // must be ignored while flushing
    ap_done = 1; ap_continue = 0;
    tick;
    ap_start = 0; ap_ready = 0;
    n_cmp++;
    if (inflight !== 3'd1) begin n_err++; $display("FAIL flush_start_ignored got inflight %0d required 1", inflight); end
    tick;
    ap_continue = 1;
    push_exp(s, tb_cyc, EXP_STALL, 2'b00);
    tick;
    ap_done = 0;
    tick; tick; tick;
    n_cmp++;
    if (rec_valid !== 1'b1 || drained !== 1'b0) begin
      n_err++; $display("FAIL flush_pending got valid=%b drained=%b required 1/0", rec_valid, drained);
    end
    rec_ready = 1;
    waited = 0;
    while (drained !== 1'b1 && waited < 20) begin tick; waited++; end
    n_cmp++;
    if (drained !== 1'b1) begin n_err++; $display("FAIL drained got %b required 1", drained); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL flush_drain pending %0d required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset;
    do_reset;
    rec_ready = 0;
    ap_start = 1; ap_ready = 1;
    tick; tick;
    ap_start = 0; ap_ready = 0;
    ap_done = 1; ap_continue = 1;
    tick;
    ap_done = 0;
    tick; tick; tick;
    do_reset;
    n_cmp++;
    if (rec_valid !== 1'b0 || inflight !== 3'd0) begin
      n_err++; $display("FAIL mid_reset got valid=%b inflight=%0d required 0/0", rec_valid, inflight);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_pipelined;
    test_orphan;
    test_overflow;
    test_fifo_full;
    test_back_to_back;
    test_finish_stall;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
